// File: rtl/dma_arg_engine_if.sv
// DMA bus between the argument engine (master) and the DMA block (slave).
// One RX read channel, one TX write channel and shared completion/status.
interface dma_arg_engine_if #(
  parameter int DATA_W = 381
) ();
  logic [31:0]       dma_rx_address;
  logic              dma_rx_start;
  logic [DATA_W-1:0] dma_rx_data;
  logic [31:0]       dma_tx_address;
  logic              dma_tx_start;
  logic [DATA_W-1:0] dma_tx_data;
  logic              dma_done;
  logic              dma_idle;
  logic              dma_error;

  modport master (
    output dma_rx_address, dma_rx_start, dma_tx_address, dma_tx_start, dma_tx_data,
    input  dma_rx_data, dma_done, dma_idle, dma_error
  );

  modport slave (
    input  dma_rx_address, dma_rx_start, dma_tx_address, dma_tx_start, dma_tx_data,
    output dma_rx_data, dma_done, dma_idle, dma_error
  );
endinterface

// File: rtl/dma_arg_engine.sv
// DMA argument-fetch / result-writeback engine. Walks a pointer table,
// dereferences each pointer into the argument buffer, starts the core, then
// writes retc results back and holds DONE/ERR until ack.
// Optional watchdog: define DMA_ARG_ENGINE_TIMEOUT_EN.
module dma_arg_engine #(
  parameter int DATA_W   = 381,
  parameter int MAX_ARGC = 4,
  parameter int MAX_RETC = 2,
  parameter int STRIDE   = 128,
  parameter int TIMEOUT  = 4096
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              start,
  input  logic                              ack,
  input  logic [31:0]                       table_base,
  input  logic [31:0]                       out_base,
  input  logic [$clog2(MAX_ARGC+1)-1:0]     argc,
  input  logic [$clog2(MAX_RETC+1)-1:0]     retc,
  output logic [MAX_ARGC*DATA_W-1:0]        args,
  output logic                              core_start,
  input  logic                              core_done,
  input  logic [MAX_RETC*DATA_W-1:0]        core_result,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [1:0]                        err_code,
  dma_arg_engine_if.master                  dma
);
  localparam int CW   = $clog2(MAX_ARGC+1);
  localparam int RW   = $clog2(MAX_RETC+1);
  localparam int MAXN = (MAX_ARGC > MAX_RETC) ? MAX_ARGC : MAX_RETC;
  localparam int KW   = $clog2(MAXN+1);
  localparam int AIW  = (MAX_ARGC > 1) ? $clog2(MAX_ARGC) : 1;
  localparam int RIW  = (MAX_RETC > 1) ? $clog2(MAX_RETC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PTR_REQ, S_PTR_WAIT, S_VAL_REQ, S_VAL_WAIT,
    S_COMPUTE, S_TX_REQ, S_TX_WAIT, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       table_base_q, out_base_q;
  logic [CW-1:0]     argc_q;
  logic [RW-1:0]     retc_q;
  logic [KW-1:0]     k_q;
  logic [31:0]       ptr_q  [MAX_ARGC];
  logic [DATA_W-1:0] args_q [MAX_ARGC];
  logic [DATA_W-1:0] res_q  [MAX_RETC];

  logic              busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic              core_start_q, core_start_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [31:0]       rx_addr_q, rx_addr_d, tx_addr_q, tx_addr_d;
  logic              rx_start_q, rx_start_d, tx_start_q, tx_start_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;

  logic              bad_cnt, last_arg, last_res, in_wait, dma_fault, dma_ok, timeout_hit;
  logic [AIW-1:0]    aidx;
  logic [RIW-1:0]    ridx;

  assign bad_cnt   = (argc == '0) || (32'(argc) > MAX_ARGC) || (32'(retc) > MAX_RETC);
  assign last_arg  = (32'(k_q) + 32'd1) == 32'(argc_q);
  assign last_res  = (32'(k_q) + 32'd1) == 32'(retc_q);
  assign in_wait   = (state_q == S_PTR_WAIT) || (state_q == S_VAL_WAIT) || (state_q == S_TX_WAIT);
  // Error beats a simultaneous done; a timeout in the same cycle also discards the data.
  assign dma_fault = in_wait && dma.dma_error;
  assign dma_ok    = in_wait && dma.dma_done && !dma.dma_error && !timeout_hit;
  assign aidx      = k_q[AIW-1:0];
  assign ridx      = k_q[RIW-1:0];

`ifdef DMA_ARG_ENGINE_TIMEOUT_EN
  logic [$clog2(TIMEOUT+1)-1:0] wdog_q;
  logic                         wdog_run;
  assign wdog_run    = in_wait || (state_q == S_COMPUTE);
  assign timeout_hit = wdog_run && (32'(wdog_q) == TIMEOUT - 1);

  // Watchdog: counts cycles spent in a wait/compute state, restarts on any state change.
  always_ff @(posedge clk) begin
    if (!resetn || (state_d != state_q)) wdog_q <= '0;
    else if (wdog_run)                    wdog_q <= wdog_q + 1'b1;
  end
`else
  // No watchdog built; waits are unbounded.
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (start) state_d = bad_cnt ? S_ERR : S_PTR_REQ;
      S_PTR_REQ:  if (dma.dma_idle) state_d = S_PTR_WAIT;
      S_PTR_WAIT: if (dma_fault) state_d = S_ERR;
                  else if (dma_ok) state_d = last_arg ? S_VAL_REQ : S_PTR_REQ;
      S_VAL_REQ:  if (dma.dma_idle) state_d = S_VAL_WAIT;
      S_VAL_WAIT: if (dma_fault) state_d = S_ERR;
                  else if (dma_ok) state_d = last_arg ? S_COMPUTE : S_VAL_REQ;
      // core_done coinciding with our own core_start pulse is stale and ignored.
      S_COMPUTE:  if (core_done && !core_start_q) state_d = (retc_q == '0) ? S_DONE : S_TX_REQ;
      S_TX_REQ:   if (dma.dma_idle) state_d = S_TX_WAIT;
      S_TX_WAIT:  if (dma_fault) state_d = S_ERR;
                  else if (dma_ok) state_d = last_res ? S_DONE : S_TX_REQ;
      S_DONE, S_ERR: if (ack) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
    if (timeout_hit && !dma_fault) state_d = S_ERR;
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    busy_d       = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_ERR));
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    core_start_d = (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
    rx_start_d   = 1'b0;
    rx_addr_d    = rx_addr_q;
    tx_start_d   = 1'b0;
    tx_addr_d    = tx_addr_q;
    tx_data_d    = tx_data_q;
    err_code_d   = err_code_q;
    case (state_q)
      S_IDLE: if (start) err_code_d = bad_cnt ? 2'd1 : 2'd0;
      S_PTR_REQ: if (dma.dma_idle) begin
        rx_start_d = 1'b1;
        rx_addr_d  = table_base_q + 32'(k_q) * 32'(STRIDE);
      end
      S_VAL_REQ: if (dma.dma_idle) begin
        rx_start_d = 1'b1;
        rx_addr_d  = ptr_q[aidx];
      end
      S_TX_REQ: if (dma.dma_idle) begin
        tx_start_d = 1'b1;
        tx_addr_d  = out_base_q + 32'(k_q) * 32'(STRIDE);
        tx_data_d  = res_q[ridx];
      end
      S_DONE, S_ERR: if (ack) err_code_d = 2'd0;
      default: ;
    endcase
    if (dma_fault)        err_code_d = 2'd2;
    else if (timeout_hit) err_code_d = 2'd3;
  end

  // Datapath and output registers: command latch, index, pointers, args, results.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      table_base_q <= '0;
      out_base_q   <= '0;
      argc_q       <= '0;
      retc_q       <= '0;
      k_q          <= '0;
      for (int i = 0; i < MAX_ARGC; i++) begin
        ptr_q[i]  <= '0;
        args_q[i] <= '0;
      end
      for (int j = 0; j < MAX_RETC; j++) res_q[j] <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      core_start_q <= 1'b0;
      err_code_q   <= 2'd0;
      rx_addr_q    <= '0;
      rx_start_q   <= 1'b0;
      tx_addr_q    <= '0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= '0;
    end else begin
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      core_start_q <= core_start_d;
      err_code_q   <= err_code_d;
      rx_addr_q    <= rx_addr_d;
      rx_start_q   <= rx_start_d;
      tx_addr_q    <= tx_addr_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      if ((state_q == S_IDLE) && start) begin
        table_base_q <= table_base;
        out_base_q   <= out_base;
        argc_q       <= argc;
        retc_q       <= retc;
        k_q          <= '0;
      end
      if (dma_ok) begin
        if (state_q == S_PTR_WAIT) ptr_q[aidx]  <= dma.dma_rx_data[31:0];
        if (state_q == S_VAL_WAIT) args_q[aidx] <= dma.dma_rx_data;
        // Index restarts at 0 when moving on from the pointer or value phase.
        k_q <= ((state_q != S_TX_WAIT) && last_arg) ? '0 : k_q + 1'b1;
      end
      if ((state_q == S_COMPUTE) && ((state_d == S_TX_REQ) || (state_d == S_DONE))) begin
        for (int j = 0; j < MAX_RETC; j++) res_q[j] <= core_result[j*DATA_W +: DATA_W];
        k_q <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < MAX_ARGC; gi++) begin : g_args
    assign args[gi*DATA_W +: DATA_W] = args_q[gi];
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign error              = error_q;
  assign err_code           = err_code_q;
  assign core_start         = core_start_q;
  assign dma.dma_rx_address = rx_addr_q;
  assign dma.dma_rx_start   = rx_start_q;
  assign dma.dma_tx_address = tx_addr_q;
  assign dma.dma_tx_start   = tx_start_q;
  assign dma.dma_tx_data    = tx_data_q;
endmodule

// File: tb/tb_dma_arg_engine.sv
// Directed self-checking bench for dma_arg_engine with a small DMA/memory
// model and a simple core model.
module tb_dma_arg_engine;
  localparam int DW = 64, MAX_ARGC = 4, MAX_RETC = 2, STRIDE = 128, TIMEOUT = 16;

  localparam logic [DW-1:0] A0  = 64'hA0A0_0000_0000_0001;
  localparam logic [DW-1:0] A1  = 64'hA1A1_0000_0000_0002;
  localparam logic [DW-1:0] A2  = 64'hA2A2_0000_0000_0003;
  localparam logic [DW-1:0] A0B = 64'hB0B0_0000_0000_0011;
  localparam logic [DW-1:0] B1  = 64'hBEEF_0000_0000_0022;
  localparam logic [DW-1:0] R0  = 64'h5151_5151_0000_0000;
  localparam logic [DW-1:0] R1  = 64'h5252_5252_0000_0001;
  localparam logic [DW-1:0] RB  = 64'hDEAD_DEAD_DEAD_DEAD;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0, ack = 1'b0;
  logic [31:0] table_base = '0, out_base = '0;
  logic [2:0]  argc = '0;
  logic [1:0]  retc = '0;
  logic [MAX_ARGC*DW-1:0] args;
  logic core_start;
  logic core_done = 1'b0;
  logic [MAX_RETC*DW-1:0] core_result = '0;
  logic busy, done, error;
  logic [1:0] err_code;

  dma_arg_engine_if #(.DATA_W(DW)) dma_bus ();

  dma_arg_engine #(
    .DATA_W(DW), .MAX_ARGC(MAX_ARGC), .MAX_RETC(MAX_RETC), .STRIDE(STRIDE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .ack(ack),
    .table_base(table_base), .out_base(out_base), .argc(argc), .retc(retc),
    .args(args), .core_start(core_start), .core_done(core_done), .core_result(core_result),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .dma(dma_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;

  // DMA / memory model state
  logic [DW-1:0] mem [logic [31:0]];
  logic [31:0]   rx_log[$];
  logic [31:0]   tx_addr_log[$];
  logic [DW-1:0] tx_data_log[$];
  int            rx_n = 0, err_rx_idx = -1, pcnt = 0;
  bit            pend = 0, pend_rx = 0, pend_err = 0;
  logic [31:0]   pend_addr = '0;

  // Core model state
  int n_core = 0, cdly = 0;
  bit core_auto = 1, core_early = 0, kick = 0;
  logic [MAX_RETC*DW-1:0] res_good = {R1, R0};
  logic [MAX_RETC*DW-1:0] res_bad  = {RB, RB};

  // DMA model: fixed 3-cycle latency, optional error injection on a chosen RX transfer.
  initial begin
    dma_bus.dma_done = 1'b0; dma_bus.dma_error = 1'b0;
    dma_bus.dma_idle = 1'b1; dma_bus.dma_rx_data = '0;
    forever begin
      @(posedge clk); #1;
      dma_bus.dma_done = 1'b0; dma_bus.dma_error = 1'b0;
      if (!resetn) begin
        pend = 0; dma_bus.dma_idle = 1'b1;
      end else if (pend) begin
        if (pcnt == 0) begin
          dma_bus.dma_done  = 1'b1;
          dma_bus.dma_error = pend_err;
          if (pend_rx) dma_bus.dma_rx_data = mem.exists(pend_addr) ? mem[pend_addr] : '0;
          pend = 0; dma_bus.dma_idle = 1'b1;
        end else pcnt = pcnt - 1;
      end
      if (resetn && dma_bus.dma_rx_start) begin
        rx_log.push_back(dma_bus.dma_rx_address);
        pend_addr = dma_bus.dma_rx_address;
        pend_err = (rx_n == err_rx_idx);
        rx_n++; pend = 1; pend_rx = 1; pcnt = 2; dma_bus.dma_idle = 1'b0;
      end
      if (resetn && dma_bus.dma_tx_start) begin
        tx_addr_log.push_back(dma_bus.dma_tx_address);
        tx_data_log.push_back(dma_bus.dma_tx_data);
        pend_err = 0; pend = 1; pend_rx = 0; pcnt = 2; dma_bus.dma_idle = 1'b0;
      end
    end
  end

  // Core model: done 3 cycles after core_start; optional stray done in the core_start cycle.
  initial begin
    forever begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (cdly > 0) begin
        cdly--;
        if (cdly == 0) begin core_done = 1'b1; core_result = res_good; end
      end
      if (kick) begin kick = 0; core_done = 1'b1; core_result = res_good; end
      if (resetn && core_start) begin
        n_core++;
        if (core_early) begin core_done = 1'b1; core_result = res_bad; end
        if (core_auto) cdly = 3;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_end(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done || error) begin ok = 1; break; end
    end
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({busy, done, error, core_start, dma_bus.dma_rx_start, dma_bus.dma_tx_start} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000000",
        {busy, done, error, core_start, dma_bus.dma_rx_start, dma_bus.dma_tx_start});
    end
    n_checks++;
    if ({err_code, dma_bus.dma_rx_address, dma_bus.dma_tx_address} !== '0 || args !== '0) begin
      n_fail++; $display("FAIL reset_values: err_code=%0d rx=%h tx=%h args=%h required all 0",
        err_code, dma_bus.dma_rx_address, dma_bus.dma_tx_address, args);
    end
    resetn = 1'b1; tick();
    $display("[%0t] reset: busy=%b done=%b error=%b", $time, busy, done, error);
  endtask

  task automatic test_three_arg();
    int b, t;
    bit ok;
    logic [31:0] exp_rx [6];
    exp_rx = '{32'h1000, 32'h1080, 32'h1100, 32'h2000, 32'h3000, 32'h4000};
    b = rx_log.size(); t = tx_addr_log.size();
    table_base = 32'h1000; out_base = 32'h6000; argc = 3'd3; retc = 2'd1;
    core_early = 0; core_auto = 1;
    n_core = 0;
    start = 1'b1; tick(); start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || dma_bus.dma_rx_start !== 1'b0) begin
      n_fail++; $display("FAIL three_arg_latency1: busy=%b rx_start=%b required 1/0", busy, dma_bus.dma_rx_start);
    end
    tick();
    n_checks++;
    if (dma_bus.dma_rx_start !== 1'b1 || dma_bus.dma_rx_address !== 32'h1000) begin
      n_fail++; $display("FAIL three_arg_latency2: rx_start=%b addr=%h required 1/00001000",
        dma_bus.dma_rx_start, dma_bus.dma_rx_address);
    end
    wait_end(200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL three_arg_wait: done=%b error=%b required done", done, error); end
    n_checks++;
    if (rx_log.size() !== b + 6) begin
      n_fail++; $display("FAIL three_arg_rx_count: got %0d required %0d", rx_log.size() - b, 6);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (rx_log[b+i] !== exp_rx[i]) begin
          n_fail++; $display("FAIL three_arg_rx_addr%0d: got %h required %h", i, rx_log[b+i], exp_rx[i]);
        end
      end
    end
    n_checks++;
    if (args[0*DW +: DW] !== A0 || args[1*DW +: DW] !== A1 || args[2*DW +: DW] !== A2) begin
      n_fail++; $display("FAIL three_arg_args: got %h %h %h required %h %h %h",
        args[0*DW +: DW], args[1*DW +: DW], args[2*DW +: DW], A0, A1, A2);
    end
    n_checks++;
    if (n_core !== 1) begin n_fail++; $display("FAIL three_arg_core_start: got %0d pulses required 1", n_core); end
    n_checks++;
    if (tx_addr_log.size() !== t + 1) begin
      n_fail++; $display("FAIL three_arg_tx_count: got %0d required 1", tx_addr_log.size() - t);
    end else if (tx_addr_log[t] !== 32'h6000 || tx_data_log[t] !== R0) begin
      n_fail++; $display("FAIL three_arg_tx: got %h/%h required 00006000/%h", tx_addr_log[t], tx_data_log[t], R0);
    end
    n_checks++;
    if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL three_arg_status: done=%b error=%b busy=%b code=%0d required 1/0/0/0",
        done, error, busy, err_code);
    end
    do_ack();
    $display("[%0t] three_arg: rx=%0d tx=%0d done_after_ack=%b", $time, rx_log.size() - b, tx_addr_log.size() - t, done);
  endtask

  task automatic test_two_result();
    int b, t;
    bit ok;
    b = rx_log.size(); t = tx_addr_log.size();
    mem[32'h2000] = A0B;
    table_base = 32'h1000; out_base = 32'h8000; argc = 3'd1; retc = 2'd2;
    core_early = 1; core_auto = 1;
    start = 1'b1; tick();
    // Inputs changing after the command is accepted must not matter.
    table_base = 32'hDEAD_0000; out_base = 32'hFFFF_0000; argc = 3'd4;
    wait_end(200, ok);
    n_checks++;
    if (!ok || done !== 1'b1) begin n_fail++; $display("FAIL two_res_wait: done=%b error=%b required done", done, error); end
    n_checks++;
    if (tx_addr_log.size() !== t + 2) begin
      n_fail++; $display("FAIL two_res_tx_count: got %0d required 2", tx_addr_log.size() - t);
    end else if (tx_addr_log[t] !== 32'h8000 || tx_data_log[t] !== R0 ||
                 tx_addr_log[t+1] !== 32'h8080 || tx_data_log[t+1] !== R1) begin
      n_fail++; $display("FAIL two_res_tx: got %h/%h %h/%h required 00008000/%h 00008080/%h",
        tx_addr_log[t], tx_data_log[t], tx_addr_log[t+1], tx_data_log[t+1], R0, R1);
    end
    n_checks++;
    if (args[0*DW +: DW] !== A0B || args[1*DW +: DW] !== A1 || args[2*DW +: DW] !== A2) begin
      n_fail++; $display("FAIL two_res_args: got %h %h %h required %h %h %h",
        args[0*DW +: DW], args[1*DW +: DW], args[2*DW +: DW], A0B, A1, A2);
    end
    repeat (5) tick();
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || rx_log.size() !== b + 2) begin
      n_fail++; $display("FAIL two_res_hold: done=%b busy=%b rx=%0d required 1/0/2", done, busy, rx_log.size() - b);
    end
    start = 1'b0;
    do_ack();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL two_res_ack: done=%b busy=%b required 0/0", done, busy);
    end
    mem[32'h2000] = A0; core_early = 0;
    $display("[%0t] two_result: tx=%0d done=%b", $time, tx_addr_log.size() - t, done);
  endtask

  task automatic test_bad_counts();
    logic [2:0] av [3];
    logic [1:0] rv [3];
    int b;
    av = '{3'd0, 3'd5, 3'd1};
    rv = '{2'd1, 2'd1, 2'd3};
    for (int i = 0; i < 3; i++) begin
      b = rx_log.size();
      argc = av[i]; retc = rv[i]; table_base = 32'h1000;
      start = 1'b1; tick(); start = 1'b0;
      n_checks++;
      if (error !== 1'b1 || err_code !== 2'd1 || busy !== 1'b0) begin
        n_fail++; $display("FAIL bad_count%0d: error=%b code=%0d busy=%b required 1/1/0", i, error, err_code, busy);
      end
      tick();
      n_checks++;
      if (rx_log.size() !== b || dma_bus.dma_rx_start !== 1'b0) begin
        n_fail++; $display("FAIL bad_count%0d_nodma: rx=%0d required 0", i, rx_log.size() - b);
      end
      do_ack();
      n_checks++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL bad_count%0d_ack: error=%b required 0", i, error); end
      $display("[%0t] bad_count: argc=%0d retc=%0d", $time, av[i], rv[i]);
    end
  endtask

  task automatic test_dma_error();
    bit ok;
    mem[32'h3000] = B1;
    err_rx_idx = rx_n + 4;
    table_base = 32'h1000; out_base = 32'h6000; argc = 3'd3; retc = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    wait_end(200, ok);
    n_checks++;
    if (!ok || error !== 1'b1 || err_code !== 2'd2) begin
      n_fail++; $display("FAIL dma_err_status: error=%b code=%0d required 1/2", error, err_code);
    end
    n_checks++;
    if (args[1*DW +: DW] !== A1) begin
      n_fail++; $display("FAIL dma_err_slot1: got %h required %h", args[1*DW +: DW], A1);
    end
    do_ack();
    err_rx_idx = -1; mem[32'h3000] = A1;
    $display("[%0t] dma_error: code=%0d after ack error=%b", $time, err_code, error);
  endtask

  task automatic test_reset_mid();
    int b, guard;
    bit ok;
    b = rx_log.size();
    table_base = 32'h1000; out_base = 32'h6000; argc = 3'd3; retc = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (rx_log.size() < b + 4 && guard < 100) begin tick(); guard++; end
    n_checks++;
    if (rx_log.size() < b + 4) begin
      n_fail++; $display("FAIL reset_mid_reach: rx=%0d required 4", rx_log.size() - b);
    end
    resetn = 1'b0; tick();
    n_checks++;
    if ({busy, done, error, err_code, dma_bus.dma_rx_start} !== 6'b0 ||
        dma_bus.dma_rx_address !== 32'h0 || args !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs: busy=%b rx_addr=%h args=%h required 0",
        busy, dma_bus.dma_rx_address, args);
    end
    resetn = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (rx_log.size() !== b + 4) begin
      n_fail++; $display("FAIL reset_mid_quiet: rx=%0d required 4", rx_log.size() - b);
    end
    b = rx_log.size();
    start = 1'b1; tick(); start = 1'b0;
    wait_end(200, ok);
    n_checks++;
    if (!ok || done !== 1'b1 || rx_log.size() !== b + 6 || args[2*DW +: DW] !== A2 || args[3*DW +: DW] !== '0) begin
      n_fail++; $display("FAIL reset_mid_rerun: done=%b rx=%0d slot2=%h slot3=%h required 1/6/%h/0",
        done, rx_log.size() - b, args[2*DW +: DW], args[3*DW +: DW], A2);
    end
    do_ack();
    $display("[%0t] reset_mid: rerun rx=%0d", $time, rx_log.size() - b);
  endtask

  task automatic test_watchdog();
    int guard;
    bit ok;
    core_auto = 0;
    table_base = 32'h1000; argc = 3'd1; retc = 2'd1;
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (core_start !== 1'b1 && guard < 100) begin tick(); guard++; end
    n_checks++;
    if (core_start !== 1'b1) begin n_fail++; $display("FAIL wdog_core_start: got %b required 1", core_start); end
`ifdef DMA_ARG_ENGINE_TIMEOUT_EN
    repeat (15) tick();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wdog_early: error=%b busy=%b required 0/1", error, busy);
    end
    tick();
    n_checks++;
    if (error !== 1'b1 || err_code !== 2'd3) begin
      n_fail++; $display("FAIL wdog_fire: error=%b code=%0d required 1/3", error, err_code);
    end
    ok = 1;
`else
    repeat (40) tick();
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL wdog_absent: error=%b busy=%b required 0/1", error, busy);
    end
    kick = 1;
    wait_end(100, ok);
    n_checks++;
    if (!ok || done !== 1'b1 || err_code !== 2'd0) begin
      n_fail++; $display("FAIL wdog_absent_done: done=%b code=%0d required 1/0", done, err_code);
    end
`endif
    do_ack();
    core_auto = 1;
    $display("[%0t] watchdog: finished ok=%b", $time, ok);
  endtask

  initial begin
    mem[32'h1000] = 64'h2000; mem[32'h1080] = 64'h3000; mem[32'h1100] = 64'h4000;
    mem[32'h2000] = A0;       mem[32'h3000] = A1;       mem[32'h4000] = A2;
    test_reset();
    test_three_arg();
    test_two_result();
    test_bad_counts();
    test_dma_error();
    test_reset_mid();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
